instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 32 +++
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Instruction-field input bus and instruction-memory write port of instr_loader.
// master = field producer, slave = the loader.
interface instr_loader_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [5:0]        in_funct;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              in_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
             in_imm, in_target, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
             in_imm, in_target, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_loader.sv
// Encodes MIPS-style instruction fields and writes them sequentially into imem.
// Optional running XOR checksum enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   instr_loader_if.slave     bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err_illegal,
   output logic              err_full,
   output logic [31:0]       checksum
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADR = '1;

   state_t            state, state_nx;
   logic              accept;
   logic              begin_session;
   logic              illegal;
   logic              at_end;
   logic [31:0]       word;
   logic [ADDR_W-1:0] wr_addr;

   // imem_addr only advances after its write cycle, so a back-to-back accept
   // targets the address one past the write currently on the bus.
   assign wr_addr = bus.imem_we ? bus.imem_addr + ADDR_W'(1) : bus.imem_addr;
   assign at_end  = (wr_addr == LAST_ADR);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      accept        = 1'b0;
      begin_session = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               begin_session = 1'b1;
               state_nx      = S_LOAD;
            end
         end
         S_LOAD: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            accept       = bus.in_valid;
            if (accept && (bus.in_last || at_end)) state_nx = S_FLUSH;
         end
         S_FLUSH: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               begin_session = 1'b1;
               state_nx      = S_LOAD;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (bus.in_kind)
         3'd0: word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
         3'd1: word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd2: word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd3: word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd4: word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd5: word = {6'b000010, bus.in_target};
         default: illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= BASE;
         bus.imem_wdata <= '0;
         count          <= '0;
         err_illegal    <= 1'b0;
         err_full       <= 1'b0;
      end else begin
         bus.imem_we <= accept;
         if (accept) begin
            bus.imem_wdata <= word;
            if (illegal)                 err_illegal <= 1'b1;
            if (at_end && !bus.in_last)  err_full    <= 1'b1;
         end
         if (begin_session) begin
            bus.imem_addr <= BASE;
            count         <= '0;
            err_illegal   <= 1'b0;
            err_full      <= 1'b0;
         end else if (bus.imem_we) begin
            bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
            count         <= count + (ADDR_W+1)'(1);
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || begin_session) checksum <= '0;
      else if (bus.imem_we)       checksum <= checksum ^ bus.imem_wdata;
   end
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized checks of instr_loader against a session-level model
// that tracks words accepted per session and derives address/count from that.
module tb_instr_loader;
   localparam int unsigned AW   = 2;
   localparam int unsigned BASE = 0;
   localparam int          SIZE = 1 << AW;
   localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_DONE = 3;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy, done, err_illegal, err_full;
   logic [AW:0] count;
   logic [31:0] checksum;

   instr_loader_if #(.ADDR_W(AW)) bus ();

   instr_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .busy(busy), .done(done), .count(count),
      .err_illegal(err_illegal), .err_full(err_full), .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // model: phase, words accepted this session, write pending, last word, flags
   int          m_phase = P_IDLE;
   int          m_na    = 0;
   bit          m_we    = 1'b0;
   logic [31:0] m_wdata = '0;
   bit          m_eill  = 1'b0;
   bit          m_efull = 1'b0;
   logic [31:0] m_cks   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word();
      case (bus.in_kind)
         3'd0: return {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
         3'd1: return {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd2: return {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd3: return {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd4: return {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd5: return {6'h02, bus.in_target};
         default: return 32'h0;
      endcase
   endfunction

   // Advance one clock: update the model from the inputs seen at the edge,
   // then compare every output half a cycle later.
   task automatic tick();
      int slot;
      logic [31:0] exp_cks;
      if (reset) begin
         m_phase = P_IDLE; m_na = 0; m_we = 0; m_wdata = '0;
         m_eill = 0; m_efull = 0; m_cks = '0;
      end else begin
         if (m_we) m_cks = m_cks ^ m_wdata;
         m_we = 0;
         case (m_phase)
            P_IDLE, P_DONE: if (start) begin
               m_phase = P_LOAD; m_na = 0; m_eill = 0; m_efull = 0; m_cks = '0;
            end
            P_LOAD: if (bus.in_valid) begin
               slot    = (BASE + m_na) % SIZE;
               m_wdata = ref_word();
               if (bus.in_kind > 3'd5) m_eill = 1;
               m_we = 1;
               m_na++;
               if (bus.in_last) m_phase = P_FLUSH;
               else if (slot == SIZE - 1) begin
                  m_efull = 1;
                  m_phase = P_FLUSH;
               end
            end
            P_FLUSH: m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_cks = m_cks;
`else
      exp_cks = 32'h0;
`endif
      chk("in_ready",    32'(bus.in_ready),   32'(m_phase == P_LOAD));
      chk("busy",        32'(busy),           32'(m_phase == P_LOAD || m_phase == P_FLUSH));
      chk("done",        32'(done),           32'(m_phase == P_DONE));
      chk("imem_we",     32'(bus.imem_we),    32'(m_we));
      chk("imem_addr",   32'(bus.imem_addr),  32'((BASE + m_na - int'(m_we)) % SIZE));
      chk("imem_wdata",  bus.imem_wdata,      m_wdata);
      chk("count",       32'(count),          32'(m_na - int'(m_we)));
      chk("err_illegal", 32'(err_illegal),    32'(m_eill));
      chk("err_full",    32'(err_full),       32'(m_efull));
      chk("checksum",    checksum,            exp_cks);
   endtask

   task automatic fields(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct,
                         input logic [15:0] imm, input logic [25:0] target, input logic last);
      bus.in_kind = kind; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.in_shamt = 5'd0; bus.in_funct = funct; bus.in_imm = imm;
      bus.in_target = target; bus.in_last = last;
   endtask

   task automatic rand_fields(input logic last);
      bus.in_kind   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      bus.in_rs     = 5'($urandom);
      bus.in_rt     = 5'($urandom);
      bus.in_rd     = 5'($urandom);
      bus.in_shamt  = 5'($urandom);
      bus.in_funct  = 6'($urandom);
      bus.in_imm    = 16'($urandom);
      bus.in_target = 26'($urandom);
      bus.in_last   = last;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0;
      fields(3'd0, '0, '0, '0, '0, '0, '0, 1'b0);
      @(negedge clk);
      tick(); tick();
      chk("rst_addr",  32'(bus.imem_addr), 32'(BASE));
      chk("rst_wdata", bus.imem_wdata, 32'h0);
      reset = 1'b0;
      tick();

      // LW rs=0 rt=2 imm=0x50, single-word session
      start = 1'b1; tick(); start = 1'b0;
      fields(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, '0, 1'b1);
      bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
      chk("lw_we",    32'(bus.imem_we), 32'h1);
      chk("lw_addr",  32'(bus.imem_addr), 32'h0);
      chk("lw_wdata", bus.imem_wdata, 32'h8C020050);
      tick();
      chk("lw_done",  32'(done), 32'h1);
      chk("lw_count", 32'(count), 32'h1);

      // R-type then J back-to-back
      start = 1'b1; tick(); start = 1'b0;
      fields(3'd0, 5'd2, 5'd3, 5'd4, 6'h20, '0, '0, 1'b0);
      bus.in_valid = 1'b1; tick();
      chk("r_wdata", bus.imem_wdata, 32'h00432020);
      fields(3'd5, '0, '0, '0, '0, '0, 26'h0000011, 1'b1);
      tick(); bus.in_valid = 1'b0;
      chk("j_we",    32'(bus.imem_we), 32'h1);
      chk("j_addr",  32'(bus.imem_addr), 32'h1);
      chk("j_wdata", bus.imem_wdata, 32'h08000011);
      tick();
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk("rj_cks", checksum, 32'h08432031);
`else
      chk("rj_cks", checksum, 32'h0);
`endif

      // illegal kind writes a NOP and the session continues
      start = 1'b1; tick(); start = 1'b0;
      fields(3'd7, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, '1, 1'b0);
      bus.in_valid = 1'b1; tick();
      chk("ill_wdata", bus.imem_wdata, 32'h0);
      chk("ill_flag",  32'(err_illegal), 32'h1);
      chk("ill_ready", 32'(bus.in_ready), 32'h1);
      fields(3'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, '0, 1'b1);
      tick(); bus.in_valid = 1'b0; tick();

      // fill all 2^AW words without last
      start = 1'b1; tick(); start = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
         rand_fields(1'b0);
         bus.in_kind = 3'd1;
         tick();
         chk("fill_addr", 32'(bus.imem_addr), 32'(i));
      end
      tick();
      chk("full_flag",  32'(err_full), 32'h1);
      chk("full_count", 32'(count), 32'(SIZE));
      chk("full_done",  32'(done), 32'h1);
      tick(); tick();
      chk("full_nowrap", 32'(bus.imem_we), 32'h0);

      // start with in_valid in DONE: only start acts
      start = 1'b1;
      chk("done_ready", 32'(bus.in_ready), 32'h0);
      tick(); start = 1'b0;
      chk("restart_busy",  32'(busy), 32'h1);
      chk("restart_we",    32'(bus.imem_we), 32'h0);
      chk("restart_flags", 32'({err_full, err_illegal}), 32'h0);

      // reset coinciding with a would-be accept, then reset right after an accept
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_we",   32'(bus.imem_we), 32'h0);
      chk("rst_idle", 32'({busy, done}), 32'h0);
      start = 1'b1; bus.in_valid = 1'b0; tick(); start = 1'b0;
      bus.in_valid = 1'b1; rand_fields(1'b0); tick();
      bus.in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2_we", 32'(bus.imem_we), 32'h0);
      tick();

      // randomized sessions
      for (int s = 0; s < 40; s++) begin
         start = 1'b1; bus.in_valid = ($urandom_range(0, 1) == 1); tick();
         start = 1'b0;
         for (int c = 0; c < 16 && (m_phase == P_LOAD || m_phase == P_FLUSH); c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            rand_fields($urandom_range(0, 5) == 0);
            start = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 39) == 0);
            tick();
            reset = 1'b0;
         end
         start = 1'b0; bus.in_valid = 1'b0;
         for (int c = 0; c < 4 && m_phase != P_IDLE && m_phase != P_DONE; c++) tick();
         bus.in_valid = ($urandom_range(0, 1) == 1);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
